// File: rtl/mic_pkg.sv
// Shared constants and types for the microphone sample arbiter.
// Exports channel count, sample width, channel index type and counter reset value.
package mic_pkg;

    localparam int MIC_NUM_CH = 4;
    localparam int MIC_DATA_W = 32;

    // Channel index width; a single channel still needs one bit.
    localparam int MIC_CH_W =
        (MIC_NUM_CH > 1) ? $clog2(MIC_NUM_CH) : 1;

    typedef logic [MIC_CH_W-1:0] mic_ch_t;

    localparam logic [31:0] MIC_SAMPLE_CNT_RST = 32'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Ports: req (pending vector), ptr (start index), grant_valid, grant (one-hot), grant_idx.
module rr_arbiter
    import mic_pkg::*;
#(
    parameter int NUM_CH = MIC_NUM_CH,
    parameter int CH_W   = MIC_CH_W
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              grant_valid,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    int idx;

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!grant_valid && req[idx]) begin
                grant_valid    = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mic_sample_arbiter.sv
// Serialises 1-clk CIC sample pulses from NUM_CH channels into one valid/ready
// stream tagged with channel index. Ports: clk, rst (async high), enable,
// cic_data/cic_valid (per-channel inputs), out_data/out_ch/out_valid/out_ready
// (output stream), overrun/overrun_clr (sticky loss flags), sample_cnt.
module mic_sample_arbiter
    import mic_pkg::*;
#(
    parameter int NUM_CH = MIC_NUM_CH,
    parameter int DATA_W = MIC_DATA_W,
    parameter int CH_W   = MIC_CH_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH*DATA_W-1:0] cic_data,
    input  logic [NUM_CH-1:0]        cic_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        overrun,
    input  logic                     overrun_clr,
    output logic [31:0]              sample_cnt
);

    logic [DATA_W-1:0] hold [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [CH_W-1:0]   rr_ptr;

    logic              gnt_valid;
    logic [NUM_CH-1:0] gnt_oh;
    logic [CH_W-1:0]   gnt_idx;

    logic              xfer;
    logic              load;
    logic              take;
    logic [NUM_CH-1:0] cap;
    logic [NUM_CH-1:0] taken;
    logic [NUM_CH-1:0] ovr_evt;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req         (pending),
        .ptr         (rr_ptr),
        .grant_valid (gnt_valid),
        .grant       (gnt_oh),
        .grant_idx   (gnt_idx)
    );

    assign xfer  = out_valid & out_ready;
    assign load  = ~out_valid | out_ready;
    // Grants are suppressed while disabled so a flush never leaks a word.
    assign take  = load & enable & gnt_valid;
    assign cap   = enable ? cic_valid : '0;
    assign taken = take ? gnt_oh : '0;
    // A sample is lost only if the old one is still waiting after this edge.
    assign ovr_evt = cap & pending & ~taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            if (!enable) begin
                pending <= '0;
            end else begin
                pending <= cap | (pending & ~taken);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (cap[i]) begin
                    hold[i] <= cic_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // New events win over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= '0;
        end else begin
            overrun <= (overrun_clr ? '0 : overrun) | ovr_evt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= hold[gnt_idx];
            out_ch    <= gnt_idx;
            if (gnt_idx == CH_W'(NUM_CH - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt_idx + CH_W'(1);
            end
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= MIC_SAMPLE_CNT_RST;
        end else if (xfer) begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mic_sample_arbiter.sv
// Bench for mic_sample_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model.
module tb_mic_sample_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [N*W-1:0]  cic_data;
    logic [N-1:0]    cic_valid;
    logic [W-1:0]    out_data;
    logic [CW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    overrun;
    logic            overrun_clr;
    logic [31:0]     sample_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    mic_sample_arbiter #(.NUM_CH(N), .DATA_W(W), .CH_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cic_data    (cic_data),
        .cic_valid   (cic_valid),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .sample_cnt  (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: waiting samples per channel, one output slot.
    bit          m_wait [N];
    logic [31:0] m_hold [N];
    logic [N-1:0] m_ovr;
    int          m_ptr;
    bit          m_ov;
    logic [31:0] m_data;
    int          m_ch;
    logic [31:0] m_cnt;
    logic [N-1:0] m_lost;
    bit          m_got;
    int          m_g;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_wait[i] = 1'b0;
                m_hold[i] = '0;
            end
            m_ovr  = '0;
            m_ptr  = 0;
            m_ov   = 1'b0;
            m_data = '0;
            m_ch   = 0;
            m_cnt  = '0;
        end else begin
            m_lost = '0;
            m_got  = 1'b0;
            m_g    = 0;
            if (m_ov && out_ready) m_cnt = m_cnt + 1;
            if (!m_ov || out_ready) begin
                if (enable) begin
                    for (int k = 0; k < N; k++) begin
                        if (!m_got && m_wait[(m_ptr + k) % N]) begin
                            m_got = 1'b1;
                            m_g   = (m_ptr + k) % N;
                        end
                    end
                end
                if (m_got) begin
                    m_ov   = 1'b1;
                    m_data = m_hold[m_g];
                    m_ch   = m_g;
                    m_ptr  = (m_g + 1) % N;
                    m_wait[m_g] = 1'b0;
                end else begin
                    m_ov = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!enable) begin
                    m_wait[i] = 1'b0;
                end else if (cic_valid[i]) begin
                    if (m_wait[i]) m_lost[i] = 1'b1;
                    m_wait[i] = 1'b1;
                    m_hold[i] = cic_data[i*W +: W];
                end
            end
            m_ovr = (overrun_clr ? '0 : m_ovr) | m_lost;
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("m_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                chk("m_data", out_data, m_data);
                chk("m_ch", 32'(out_ch), 32'(m_ch));
            end
            chk("m_overrun", 32'(overrun), 32'(m_ovr));
            chk("m_cnt", sample_cnt, m_cnt);
        end
    end

    task automatic setd(input int ch, input logic [31:0] v);
        cic_data[ch*W +: W] = v;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        cic_valid = m;
        @(negedge clk);
        cic_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        cic_data = '0;
        cic_valid = '0;
        out_ready = 1'b0;
        overrun_clr = 1'b0;
        #1;
        do_reset();
        chk_on = 1'b1;

        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ch", 32'(out_ch), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_cnt", sample_cnt, 32'd0);

        // Single sample, two-edge latency
        enable = 1'b1;
        out_ready = 1'b1;
        setd(2, 32'h0000_1234);
        pulse(4'b0100);
        chk("t1_lat", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", out_data, 32'h1234);
        chk("t1_ch", 32'(out_ch), 32'd2);
        @(negedge clk);
        chk("t1_drop", 32'(out_valid), 32'd0);
        chk("t1_cnt", sample_cnt, 32'd1);
        chk("t1_ovr", 32'(overrun), 32'd0);

        // Simultaneous burst drains round-robin
        do_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) setd(i, 32'hA0 + 32'(i));
        pulse(4'hF);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("t2_ch", 32'(out_ch), 32'(k));
            chk("t2_data", out_data, 32'hA0 + 32'(k));
            @(negedge clk);
        end
        chk("t2_idle", 32'(out_valid), 32'd0);
        chk("t2_cnt", sample_cnt, 32'd4);

        // Backpressure and overrun
        do_reset();
        enable = 1'b1;
        out_ready = 1'b0;
        setd(1, 32'h11);
        pulse(4'b0010);
        @(negedge clk);
        chk("t3_held", out_data, 32'h11);
        setd(1, 32'h77);
        pulse(4'b0010);
        setd(1, 32'h22);
        pulse(4'b0010);
        chk("t3_ovr", 32'(overrun), 32'h2);
        chk("t3_stable", out_data, 32'h11);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_next", out_data, 32'h22);
        chk("t3_nch", 32'(out_ch), 32'd1);
        @(negedge clk);
        chk("t3_idle", 32'(out_valid), 32'd0);
        chk("t3_cnt", sample_cnt, 32'd2);

        // Overrun clear racing a new event
        do_reset();
        enable = 1'b1;
        out_ready = 1'b0;
        setd(3, 32'h31);
        pulse(4'b1000);
        @(negedge clk);
        setd(3, 32'h32);
        pulse(4'b1000);
        setd(3, 32'h33);
        pulse(4'b1000);
        chk("t4_set", 32'(overrun), 32'h8);
        setd(3, 32'h34);
        overrun_clr = 1'b1;
        pulse(4'b1000);
        overrun_clr = 1'b0;
        chk("t4_race", 32'(overrun), 32'h8);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("t4_clr", 32'(overrun), 32'h0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Enable flush
        do_reset();
        enable = 1'b1;
        out_ready = 1'b0;
        setd(0, 32'h50);
        pulse(4'b0001);
        @(negedge clk);
        setd(1, 32'h51);
        setd(2, 32'h52);
        pulse(4'b0110);
        enable = 1'b0;
        @(negedge clk);
        setd(3, 32'h53);
        pulse(4'b1000);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_cnt1", sample_cnt, 32'd1);
        repeat (3) @(negedge clk);
        chk("t5_none", 32'(out_valid), 32'd0);
        chk("t5_cnt", sample_cnt, 32'd1);

        // Async reset mid-transfer
        enable = 1'b1;
        out_ready = 1'b0;
        setd(2, 32'h66);
        pulse(4'b0100);
        @(negedge clk);
        chk("t6_pre", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_cnt", sample_cnt, 32'd0);
        chk("t6_ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        setd(0, 32'h70);
        pulse(4'b0001);
        @(negedge clk);
        chk("t6_ch", 32'(out_ch), 32'd0);
        chk("t6_data", out_data, 32'h70);

        // Randomized traffic
        repeat (4000) begin
            enable = ($urandom_range(0, 19) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) setd(i, $urandom);
            cic_valid = N'($urandom & $urandom);
            @(negedge clk);
        end
        cic_valid = '0;
        overrun_clr = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
